// File: rtl/controller_pkg.sv
// controller_pkg: shared button indices and pad-reader FSM states
// for the game pad input stage.
package controller_pkg;

    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT,
        CLK_HI,
        CLK_LO,
        DONE
    } pad_state_t;

endpackage

// File: rtl/nes_pad_reader_sync2.sv
// sync2: parameterised two-flop synchroniser with a
// configurable asynchronous reset value.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES pad, drives latch/clock, deserialises buttons.
// Define NES_PAD_EDGE_EN to add the buttons_rise newly-pressed strobe.
module nes_pad_reader
    import controller_pkg::*;
#(
    parameter int HALF_BIT = 300,
    parameter int POLL_DIV = 833_333
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctrl_data,
    output logic                   ctrl_latch,
    output logic                   ctrl_clk,
    output logic [NUM_BUTTONS-1:0] buttons,
    output logic                   buttons_valid
`ifdef NES_PAD_EDGE_EN
    ,
    output logic [NUM_BUTTONS-1:0] buttons_rise
`endif
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int HW = $clog2(2 * HALF_BIT);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_BIT - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_BIT - 1);

    logic                   data_sync;
    logic [PW-1:0]          poll_cnt;
    logic                   tick;
    pad_state_t             state;
    pad_state_t             state_n;
    logic [HW-1:0]          phase;
    logic [2:0]             bit_idx;
    logic [NUM_BUTTONS-1:0] shift;
    logic                   sample;

    sync2 #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (ctrl_data),
        .q    (data_sync)
    );

    assign tick = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
        end
    end

    always_comb begin
        state_n = state;
        sample  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) state_n = LATCH;
            end
            LATCH: begin
                if (phase == LATCH_LAST) state_n = WAIT;
            end
            WAIT: begin
                if (phase == HALF_LAST) begin
                    sample  = 1'b1;
                    state_n = CLK_HI;
                end
            end
            CLK_HI: begin
                if (phase == HALF_LAST) state_n = CLK_LO;
            end
            CLK_LO: begin
                if (phase == HALF_LAST) begin
                    sample  = 1'b1;
                    state_n = (bit_idx == 3'd7) ? DONE : CLK_HI;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so they rise with the state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            ctrl_latch <= 1'b0;
            ctrl_clk   <= 1'b0;
        end else begin
            state      <= state_n;
            ctrl_latch <= (state_n == LATCH);
            ctrl_clk   <= (state_n == CLK_HI);
            if (state_n != state || state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + HW'(1);
            end
            if (state == LATCH) begin
                bit_idx <= '0;
            end else if (sample) begin
                shift[bit_idx] <= data_sync;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buttons       <= '0;
            buttons_valid <= 1'b0;
        end else begin
            buttons_valid <= (state == DONE);
            if (state == DONE) buttons <= ~shift;
        end
    end

`ifdef NES_PAD_EDGE_EN
    logic [NUM_BUTTONS-1:0] prev_buttons;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_buttons <= '0;
            buttons_rise <= '0;
        end else begin
            buttons_rise <= '0;
            if (state == DONE) begin
                buttons_rise <= ~shift & ~prev_buttons;
                prev_buttons <= ~shift;
            end
        end
    end
`endif

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Upstream input stage for `VGAGraphics`. It polls an NES-style serial game pad on a fixed period, drives the pad's latch and clock pins, and deserialises the active-low data line. It presents an 8-bit active-high `buttons` vector with a one-cycle `buttons_valid` strobe to the graphics/game-state logic.

## Interface
- `HALF_BIT`, default 300: cycles per half serial-clock period (6 µs at 50 MHz); must be ≥ 4.
- `POLL_DIV`, default 833_333: cycles between poll starts (60 Hz at 50 MHz); must be > 17·HALF_BIT+1.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high.
- `ctrl_data`  in  1  pad serial data, asynchronous, active-low (0 = pressed).
- `ctrl_latch`  out  1  pad latch pin.
- `ctrl_clk`  out  1  pad clock pin.
- `buttons`  out  8  pressed = 1; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- `buttons_valid`  out  1  one-cycle strobe when `buttons` updates.
- `buttons_rise`  out  8  one-cycle newly-pressed vector (only with `NES_PAD_EDGE_EN`).

## Operation
- `ctrl_data` passes through a 2-flop synchroniser that resets to 1 (unpressed).
- Poll counter, width $clog2(POLL_DIV):
  - free-running 0..POLL_DIV-1, then wraps to 0;
  - `tick` is asserted when count == POLL_DIV-1.
- FSM states:
  - IDLE: wait for `tick`.
  - LATCH: `ctrl_latch`=1 for 2·HALF_BIT cycles.
  - WAIT: both pins 0 for HALF_BIT cycles; samples bit 0 on the last cycle.
  - CLK_HI: `ctrl_clk`=1 for HALF_BIT cycles.
  - CLK_LO: `ctrl_clk`=0 for HALF_BIT cycles; samples the next bit on the last cycle, then goes to CLK_HI, or to DONE after bit 7.
  - DONE: one cycle; `buttons` <= ~shift, `buttons_valid`=1; returns to IDLE.
- Sampling: a bit is sampled from the synchronised data into shift[bit_idx]. bit_idx is 3 bits and increments per sample.
- Pulse count: exactly 7 `ctrl_clk` rising edges per transaction.
- Phase counter width is $clog2(2·HALF_BIT). It reloads to 0 on every state change.
- `tick` while the FSM is not in IDLE is dropped; no queuing, and the poll counter is not disturbed.
- `ctrl_latch` and `ctrl_clk` are registered state decodes, glitch-free and never high together.
- `buttons` holds its value between updates.

## Timing
- Reset values:
  - `ctrl_latch`, `ctrl_clk`, `buttons_valid` = 0;
  - `buttons` = 0x00, `buttons_rise` = 0x00;
  - FSM in IDLE, all counters 0, synchroniser = 2'b11.
- First `ctrl_latch` rise: on the clock edge POLL_DIV cycles after reset deassertion. Thereafter every POLL_DIV cycles.
- Transaction length: 17·HALF_BIT + 1 cycles from the `ctrl_latch` rise to the `buttons_valid` cycle. The new `buttons` value is visible in the same cycle as `buttons_valid`.
- Data sample point: the last cycle of each low phase, ≥ HALF_BIT-2 cycles after the pad's shift edge. This covers the synchroniser latency.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously). The partial shift data is discarded. The next poll follows the first rule above.

## Configuration
- `NES_PAD_EDGE_EN` defined:
  - a `prev_buttons` register (reset 0x00) is present;
  - in the DONE cycle, `buttons_rise` = new & ~prev_buttons, and `prev_buttons` <= new;
  - `buttons_rise` is 0 in all other cycles.
- Not defined: the `buttons_rise` port and `prev_buttons` register are absent.

## Structure
- Shared package `controller_pkg`:
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - FSM state enum (IDLE, LATCH, WAIT, CLK_HI, CLK_LO, DONE);
  - NUM_BUTTONS = 8.
- One sub-module, `sync2`: a parameterised 2-flop synchroniser with an async-reset value parameter.
- Poll counter and FSM live in `nes_pad_reader`.

## Test plan
All scenarios use HALF_BIT=4, POLL_DIV=100, and a behavioural pad model that shifts on `ctrl_clk` rise and reloads on `ctrl_latch`.
- Reset, then release -> all outputs 0 during reset. First `ctrl_latch` rise 100 cycles after release, high for 8 cycles, followed by exactly 7 `ctrl_clk` pulses of 4 high/4 low.
- Pad holds A+Start -> `buttons`=8'h09 with `buttons_valid` high for 1 cycle, 69 cycles after the `ctrl_latch` rise.
- `ctrl_data` tied 1 (no pad) -> `buttons`=8'h00 every poll. All buttons pressed -> 8'hFF; released before the next poll -> 8'h00 on the next poll.
- Change the pad state during a transaction -> the value in effect at each sample point is captured, verified per bit against the model.
- Assert `reset` during CLK_HI of bit 4 -> `ctrl_clk`, `ctrl_latch` and `buttons` are 0 the same cycle. After release, a full clean transaction starts 100 cycles later.
- With `NES_PAD_EDGE_EN`: A pressed and held over 3 polls -> `buttons_rise`=8'h01 at the first `buttons_valid` only, 8'h00 at the next two. Release then re-press -> pulses again.
